// File: rtl/osd_key_repeat.sv
// Four-button debounce plus a shared press/auto-repeat FSM that emits single-cycle key pulses.
// Define OSD_KEY_AUTOREPEAT_EN to enable auto-repeat; otherwise each press yields exactly one pulse.
module osd_key_repeat #(
  parameter int CLK_HZ          = 32_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic key_left,
  output logic key_right,
  output logic key_up,
  output logic key_down,
  output logic key_any,
  output logic held
);

  localparam int DB_CYC  = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DLY_CYC = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int RPT_CYC = CLK_HZ / 1000 * REPEAT_RATE_MS;

  if (DB_CYC < 1 || DLY_CYC < 1 || RPT_CYC < 1) begin : g_bad_timing
    $error("osd_key_repeat: DB_CYC, DLY_CYC and RPT_CYC must each be at least 1");
  end

  localparam int DBW = (DB_CYC >= 1) ? $clog2(DB_CYC + 1) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

`ifdef OSD_KEY_AUTOREPEAT_EN
  localparam int TMAX = (DLY_CYC > RPT_CYC) ? DLY_CYC : RPT_CYC;
  localparam int TW   = (TMAX >= 1) ? $clog2(TMAX + 1) : 1;
  localparam logic [TW-1:0] DLY_LOAD = TW'(DLY_CYC - 1);
  localparam logic [TW-1:0] RPT_LOAD = TW'(RPT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_DELAY,
    S_REPEAT
  } state_t;

  // Bit order: 0=left, 1=right, 2=up, 3=down
  logic [3:0]     w_btn;
  logic [3:0]     r_sync1;
  logic [3:0]     r_sync2;
  logic [3:0]     r_db;
  logic [DBW-1:0] r_dbcnt [4];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_idx;
  logic [1:0] w_idx_nxt;
  logic [1:0] w_pri;
  logic       w_act;
  logic       w_pulse;
  logic [3:0] w_key_nxt;
  logic [3:0] r_key;
  logic       r_any;
`ifdef OSD_KEY_AUTOREPEAT_EN
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
`endif

  assign w_btn = {btn_down, btn_up, btn_right, btn_left};
  assign w_act = r_db[r_idx];

  // Synchronizers and per-button debounce
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int unsigned i = 0; i < 4; i++) r_dbcnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_dbcnt[i] <= '0;
        end else if (r_dbcnt[i] == DB_LAST) begin
          r_db[i]    <= r_sync2[i];
          r_dbcnt[i] <= '0;
        end else begin
          r_dbcnt[i] <= r_dbcnt[i] + DBW'(1);
        end
      end
    end
  end

  always_comb begin
    w_pri = 2'd3;
    if (r_db[0])      w_pri = 2'd0;
    else if (r_db[1]) w_pri = 2'd1;
    else if (r_db[2]) w_pri = 2'd2;
  end

  // State register; key outputs are registered alongside
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_key   <= '0;
      r_any   <= 1'b0;
`ifdef OSD_KEY_AUTOREPEAT_EN
      r_timer <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_key   <= w_key_nxt;
      r_any   <= |w_key_nxt;
`ifdef OSD_KEY_AUTOREPEAT_EN
      r_timer <= w_timer_nxt;
`endif
    end
  end

  // Next state: release of the active key beats any timer expiry
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pulse     = 1'b0;
`ifdef OSD_KEY_AUTOREPEAT_EN
    w_timer_nxt = r_timer;
`endif
    case (r_state)
      S_IDLE: begin
        if (|r_db) begin
          w_state_nxt = S_PRESS;
          w_idx_nxt   = w_pri;
        end
      end
      S_PRESS: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_pulse     = 1'b1;
          w_state_nxt = S_DELAY;
`ifdef OSD_KEY_AUTOREPEAT_EN
          w_timer_nxt = DLY_LOAD;
`endif
        end
      end
`ifdef OSD_KEY_AUTOREPEAT_EN
      S_DELAY, S_REPEAT: begin
        if (!w_act) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == '0) begin
          w_pulse     = 1'b1;
          w_timer_nxt = RPT_LOAD;
          w_state_nxt = S_REPEAT;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
`else
      S_DELAY: begin
        if (!w_act) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_key_nxt = '0;
    if (w_pulse) w_key_nxt = 4'(1) << r_idx;
    held = (r_state != S_IDLE);
  end

  assign key_left  = r_key[0];
  assign key_right = r_key[1];
  assign key_up    = r_key[2];
  assign key_down  = r_key[3];
  assign key_any   = r_any;

endmodule

// File: tb/tb_osd_key_repeat.sv
// Randomized bench for osd_key_repeat against an edge-counting reference model.
module tb_osd_key_repeat;

  localparam int DB  = 4;
  localparam int DLY = 20;
  localparam int RPT = 5;
`ifdef OSD_KEY_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic key_left, key_right, key_up, key_down, key_any, held;

  always #5 clk = ~clk;

  osd_key_repeat #(
    .CLK_HZ(1000),
    .DEBOUNCE_MS(4),
    .REPEAT_DELAY_MS(20),
    .REPEAT_RATE_MS(5)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .key_left(key_left),
    .key_right(key_right),
    .key_up(key_up),
    .key_down(key_down),
    .key_any(key_any),
    .held(held)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: press time plus elapsed-edge arithmetic decides pulses
  logic [3:0] m_sync1 = '0, m_sync2 = '0, m_db = '0, e_key = '0;
  int m_run [4] = '{0, 0, 0, 0};
  bit m_held = 1'b0;
  int m_idx = 0;
  int m_press = 0;
  int n_edge = 0;

  task automatic model_step(input logic rst_n, input logic [3:0] raw);
    logic [3:0] old_db;
    int k;
    e_key = '0;
    if (!rst_n) begin
      m_sync1 = '0; m_sync2 = '0; m_db = '0; m_held = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      old_db = m_db;
      if (!m_held) begin
        if (old_db != 4'b0) begin
          m_held = 1'b1;
          for (int i = 3; i >= 0; i--) if (old_db[i]) m_idx = i;
          m_press = n_edge;
        end
      end else if (!old_db[m_idx]) begin
        m_held = 1'b0;
      end else begin
        k = n_edge - m_press;
        if (k == 1 || (AUTO && k - 1 >= DLY && (k - 1 - DLY) % RPT == 0))
          e_key[m_idx] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_sync2[i] != old_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_db[i] = m_sync2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = raw;
    end
    n_edge++;
  endtask

  bit lat_arm = 1'b0;
  int lat_base = 0;
  int lat_got = -1;

  task automatic arm_latency();
    lat_arm = 1'b1;
    lat_base = n_edge;
    lat_got = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(reset_n, {btn_down, btn_up, btn_right, btn_left});
    #1;
    check("key", 32'({key_down, key_up, key_right, key_left}), 32'(e_key));
    check("key_any", 32'(key_any), 32'(|e_key));
    check("held", 32'(held), 32'(m_held));
    if (lat_arm && lat_got < 0 && key_left) lat_got = (n_edge - 1) - lat_base;
  endtask

  int rem [4];
  logic [3:0] lvl;

  initial begin
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Left held for 60 edges
    arm_latency();
    btn_left = 1'b1;
    repeat (60) tick();
    check("lat_press", 32'(lat_got), 32'(DB + 3));
    lat_arm = 1'b0;
    btn_left = 1'b0;
    repeat (15) tick();

    // Up glitching: two cycles high, one low
    for (int c = 0; c < 30; c++) begin
      btn_up = (c % 3 != 2);
      tick();
    end
    btn_up = 1'b0;
    repeat (15) tick();

    // Right and down together, then right released
    btn_right = 1'b1; btn_down = 1'b1;
    repeat (40) tick();
    btn_right = 1'b0;
    repeat (30) tick();
    btn_down = 1'b0;
    repeat (15) tick();

    // Reset mid-hold
    btn_left = 1'b1;
    repeat (15) tick();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    arm_latency();
    repeat (30) tick();
    check("lat_reset", 32'(lat_got), 32'(DB + 3));
    lat_arm = 1'b0;
    btn_left = 1'b0;
    repeat (15) tick();

    // Debounced release lands on the first-repeat edge
    btn_left = 1'b1;
    repeat (21) tick();
    btn_left = 1'b0;
    repeat (15) tick();

    // Random button activity with occasional short glitches and resets
    for (int i = 0; i < 4; i++) rem[i] = 0;
    lvl = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          lvl[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(5, 60));
        end
        rem[i]--;
      end
      {btn_down, btn_up, btn_right, btn_left} = lvl;
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
